// File: rtl/imem_loader_if.sv
// Bundles the byte-stream handshake, the BRAM write port and the loader status lines.
// The slave modport is the loader's view. The master modport is the host/boot-controller view.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              i_start;
  logic [ADDR_W:0]   i_num_words;
  logic              i_byte_valid;
  logic [7:0]        i_byte_data;
  logic              o_byte_ready;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_din;
  logic              o_busy;
  logic              o_done;
  logic              o_cpu_hold;

  modport slave (
    input  i_start, i_num_words, i_byte_valid, i_byte_data,
    output o_byte_ready, o_mem_we, o_mem_addr, o_mem_din, o_busy, o_done, o_cpu_hold
  );

  modport master (
    output i_start, i_num_words, i_byte_valid, i_byte_data,
    input  o_byte_ready, o_mem_we, o_mem_addr, o_mem_din, o_busy, o_done, o_cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them to consecutive
// instruction-memory word addresses. It holds the CPU in reset until the requested count has been written.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W:0]   r_target;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic              r_byte_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_din;
  logic              r_busy;
  logic              r_done;
  logic              r_cpu_hold;

  logic [ADDR_W:0]   w_clamped;
  logic [ADDR_W:0]   w_word_next;
  logic              w_accept;

  assign w_clamped   = (bus.i_num_words > L_DEPTH) ? L_DEPTH : bus.i_num_words;
  assign w_word_next = r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
  assign w_accept    = bus.i_byte_valid & r_byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_word_cnt   <= '0;
      r_target     <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            if (w_clamped == '0) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state      <= S_RECV;
              r_target     <= w_clamped;
              r_word_cnt   <= '0;
              r_byte_cnt   <= '0;
              r_mem_addr   <= '0;
              r_done       <= 1'b0;
              r_cpu_hold   <= 1'b1;
              r_busy       <= 1'b1;
              r_byte_ready <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_asm      <= {r_asm[15:0], bus.i_byte_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Fourth byte completes the word: present it on the write port next cycle.
            if (r_byte_cnt == 2'd3) begin
              r_mem_din    <= {r_asm, bus.i_byte_data};
              r_mem_we     <= 1'b1;
              r_byte_ready <= 1'b0;
              r_state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_mem_we   <= 1'b0;
          r_word_cnt <= w_word_next;
          if (w_word_next == r_target) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_mem_addr   <= r_mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_byte_ready <= 1'b1;
            r_state      <= S_RECV;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_mem_we     <= 1'b0;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_byte_ready = r_byte_ready;
  assign bus.o_mem_we     = r_mem_we;
  assign bus.o_mem_addr   = r_mem_addr;
  assign bus.o_mem_din    = r_mem_din;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_cpu_hold   = r_cpu_hold;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. A negedge monitor logs every BRAM write.
// The main sequence checks the handshake, timing and written words against hand-computed values.
module tb_imem_loader;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [36:0] wr_q[$];

  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_mem_we) begin
      wr_q.push_back({bus.o_mem_addr, bus.o_mem_din});
      $display("[TB] write addr=%0d data=%h", bus.o_mem_addr, bus.o_mem_din);
    end
  end

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [5:0] n);
    bus.i_start     = 1'b1;
    bus.i_num_words = n;
    tick();
    bus.i_start     = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles and holds it until the loader accepts it.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    logic rdy;
    bus.i_byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    bus.i_byte_valid = 1'b1;
    bus.i_byte_data  = b;
    waits = 0;
    forever begin
      rdy = bus.o_byte_ready;
      tick();
      if (rdy) break;
      waits++;
      if (waits > 20) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: byte %h never accepted", b);
        break;
      end
    end
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int wt;
    send_byte(w[31:24], 0, wt);
    send_byte(w[23:16], 0, wt);
    send_byte(w[15:8],  0, wt);
    send_byte(w[7:0],   0, wt);
  endtask

  initial begin
    int wt;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_num_words = '0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle after reset: {hold,done,busy,ready,we}
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", {bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_byte_ready, bus.o_mem_we}, 5'b10000);
      tick();
    end
    check("idle_addr_din", {bus.o_mem_addr, bus.o_mem_din}, 37'h0);

    // Zero-length load completes on the next edge.
    pulse_start(6'd0);
    check("zero_outputs", {bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_byte_ready, bus.o_mem_we}, 5'b01000);
    check("zero_nowrite", wr_q.size(), 0);

    // Two words back-to-back.
    pulse_start(6'd2);
    check("start_outputs", {bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_byte_ready, bus.o_mem_we}, 5'b10110);
    send_word(32'h20010005);
    check("w0_port", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din}, {1'b1, 5'd0, 32'h20010005});
    check("w0_ready_low", bus.o_byte_ready, 1'b0);
    send_word(32'hDEADBEEF);
    check("w1_port", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din}, {1'b1, 5'd1, 32'hDEADBEEF});
    check("w1_not_done", bus.o_done, 1'b0);
    tick();
    check("b2b_done", {bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_byte_ready, bus.o_mem_we}, 5'b01000);
    check("b2b_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("b2b_wr0", wr_q[0], {5'd0, 32'h20010005});
      check("b2b_wr1", wr_q[1], {5'd1, 32'hDEADBEEF});
    end
    wr_q.delete();

    // Same load with valid toggling, 5th byte presented during WRITE.
    pulse_start(6'd2);
    check("tog_done_cleared", {bus.o_cpu_hold, bus.o_done}, 2'b10);
    send_byte(8'h20, 0, wt);
    send_byte(8'h01, 1, wt);
    send_byte(8'h00, 1, wt);
    send_byte(8'h05, 1, wt);
    send_byte(8'hDE, 0, wt);
    check("tog_held_in_write", wt, 1);
    send_byte(8'hAD, 1, wt);
    send_byte(8'hBE, 1, wt);
    send_byte(8'hEF, 1, wt);
    tick();
    check("tog_done", {bus.o_cpu_hold, bus.o_done, bus.o_busy}, 3'b010);
    check("tog_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("tog_wr0", wr_q[0], {5'd0, 32'h20010005});
      check("tog_wr1", wr_q[1], {5'd1, 32'hDEADBEEF});
    end
    wr_q.delete();

    // Clamped load of 40 -> 32 words; stray starts are ignored.
    pulse_start(6'd40);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) pulse_start(6'd0);
      if (i == 20) begin
        send_byte(8'h00, 0, wt);
        send_byte(8'h00, 0, wt);
        pulse_start(6'd3);
        send_byte(8'h00, 0, wt);
        send_byte(8'(i), 0, wt);
      end else begin
        send_word(32'(i));
      end
      if (i < 31) check("clamp_busy", {bus.o_busy, bus.o_done}, 2'b10);
    end
    check("clamp_last_port", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din}, {1'b1, 5'd31, 32'd31});
    tick();
    check("clamp_done", {bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_mem_addr}, {3'b010, 5'd31});
    repeat (6) tick();
    check("clamp_count", wr_q.size(), 32);
    if (wr_q.size() == 32) begin
      for (int i = 0; i < 32; i++) check("clamp_wr", wr_q[i], {5'(i), 32'(i)});
    end
    wr_q.delete();

    // Asynchronous reset mid-load, then a clean single-word load.
    pulse_start(6'd2);
    send_word(32'hCAFEF00D);
    send_byte(8'hAA, 0, wt);
    send_byte(8'hBB, 0, wt);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {bus.o_cpu_hold, bus.o_done, bus.o_busy, bus.o_byte_ready, bus.o_mem_we}, 5'b10000);
    check("rst_addr_din", {bus.o_mem_addr, bus.o_mem_din}, 37'h0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_q.delete();
    pulse_start(6'd1);
    send_word(32'h11223344);
    check("post_rst_port", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_din}, {1'b1, 5'd0, 32'h11223344});
    tick();
    check("post_rst_done", {bus.o_cpu_hold, bus.o_done, bus.o_busy}, 3'b010);
    check("post_rst_count", wr_q.size(), 1);
    if (wr_q.size() == 1) check("post_rst_wr", wr_q[0], {5'd0, 32'h11223344});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
